// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile write-port controller.
// Geometry is 8 harts x 32 registers, one write port.
package regfile_pkg;

    localparam int RF_DEPTH    = 256;
    localparam int RF_ADDR_W   = 8;
    localparam int RF_DATA_W   = 32;
    localparam int RF_REG_BITS = 5;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] waddr;
        logic [RF_DATA_W-1:0] wdata;
    } wb_req_t;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Walks a clear index over every regfile entry, one per cycle while advancing.
// The index carries one extra bit so the terminal compare against DEPTH-1 is exact.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    input  logic              advance,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              done
);

    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] clr_idx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            clr_idx <= '0;
        end else if (advance) begin
            clr_idx <= done ? '0 : clr_idx + ONE;
        end
    end

    assign done     = advance && (clr_idx == LAST);
    assign clr_addr = clr_idx[ADDR_W-1:0];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port controller: arbitrates execute (A, priority) against load (B)
// with a starvation guard for B, drops x0 writes, and sequences full-regfile clears.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH        = RF_DEPTH,
    parameter int ADDR_W       = RF_ADDR_W,
    parameter int DATA_W       = RF_DATA_W,
    parameter int REG_BITS     = RF_REG_BITS,
    parameter int STARVE_LIMIT = 3,
    parameter int ZERO_DROP    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wren,
    output logic              busy
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0]   STARVE_ONE = SW'(1);

    state_t            state;
    state_t            state_next;
    logic [SW-1:0]     starve_cnt;
    logic              force_b;
    logic              a_hs;
    logic              b_hs;
    logic              grant;
    logic              drop;
    logic              clr_done;
    logic [ADDR_W-1:0] clr_addr;
    wb_req_t           a_req;
    wb_req_t           b_req;
    wb_req_t           sel_req;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .restart  (state == RUN && clear_req),
        .advance  (state == CLEAR),
        .clr_addr (clr_addr),
        .done     (clr_done)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        force_b    = 1'b0;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                force_b = b_valid && (starve_cnt == STARVE_MAX);
                if (clear_req) begin
                    state_next = CLEAR;
                end else begin
                    // a_ready is deliberately independent of a_valid; A holds until accepted.
                    a_ready = !force_b;
                    b_ready = !a_valid || force_b;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign busy    = (state == CLEAR);
    assign a_hs    = a_valid && a_ready;
    assign b_hs    = b_valid && b_ready;
    assign grant   = a_hs || b_hs;
    assign a_req   = '{waddr: a_waddr, wdata: a_wdata};
    assign b_req   = '{waddr: b_waddr, wdata: b_wdata};
    assign sel_req = b_hs ? b_req : a_req;
    assign drop    = (ZERO_DROP != 0) && (sel_req.waddr[REG_BITS-1:0] == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Counts consecutive cycles in which B waited while A was granted.
    always_ff @(posedge clock) begin
        if (reset || state != RUN || clear_req) begin
            starve_cnt <= '0;
        end else if (b_hs || !b_valid) begin
            starve_cnt <= '0;
        end else if (a_hs && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + STARVE_ONE;
        end
    end

    // A dropped x0 write still updates address/data; only the enable is suppressed.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_wren  <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (state == CLEAR) begin
            rf_wren  <= 1'b1;
            rf_waddr <= clr_addr;
            rf_wdata <= '0;
        end else if (clear_req) begin
            rf_wren  <= 1'b0;
        end else begin
            rf_wren <= grant && !drop;
            if (grant) begin
                rf_waddr <= sel_req.waddr;
                rf_wdata <= sel_req.wdata;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a cycle-level model checked every
// negedge, plus directed scenarios with hand-computed expectations.
module tb_regfile_wb_arbiter;

    localparam int DEPTH  = 256;
    localparam int STARVE = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [7:0]  a_waddr = '0;
    logic [31:0] a_wdata = '0;
    logic        b_valid = 1'b0;
    logic [7:0]  b_waddr = '0;
    logic [31:0] b_wdata = '0;
    logic        clear_req = 1'b0;

    logic        a_ready, b_ready, rf_wren, busy;
    logic [7:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        a_ready_k, b_ready_k, rf_wren_k, busy_k;
    logic [7:0]  rf_waddr_k;
    logic [31:0] rf_wdata_k;

    always #5 clock = ~clock;

    regfile_wb_arbiter u_dut (
        .clock (clock), .reset (reset),
        .a_valid (a_valid), .a_ready (a_ready), .a_waddr (a_waddr), .a_wdata (a_wdata),
        .b_valid (b_valid), .b_ready (b_ready), .b_waddr (b_waddr), .b_wdata (b_wdata),
        .clear_req (clear_req),
        .rf_waddr (rf_waddr), .rf_wdata (rf_wdata), .rf_wren (rf_wren), .busy (busy)
    );

    regfile_wb_arbiter #(.ZERO_DROP(0)) u_dut_keep (
        .clock (clock), .reset (reset),
        .a_valid (a_valid), .a_ready (a_ready_k), .a_waddr (a_waddr), .a_wdata (a_wdata),
        .b_valid (b_valid), .b_ready (b_ready_k), .b_waddr (b_waddr), .b_wdata (b_wdata),
        .clear_req (clear_req),
        .rf_waddr (rf_waddr_k), .rf_wdata (rf_wdata_k), .rf_wren (rf_wren_k), .busy (busy_k)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid = 0;
    bit          m_clearing;
    int          m_clr_cnt;
    int          m_losses;
    logic        m_wren, m_wren_k;
    logic [7:0]  m_waddr;
    logic [31:0] m_wdata;

    // {a_ready, b_ready} from the arbitration rules and the current inputs.
    function automatic logic [1:0] model_ready();
        bit starved;
        if (m_clearing || clear_req) return 2'b00;
        starved = b_valid && (m_losses >= STARVE);
        return {!starved, !a_valid || starved};
    endfunction

    always @(posedge clock) begin
        logic [1:0] rdy;
        bit ahs, bhs;
        rdy = model_ready();
        if (reset) begin
            m_valid = 1; m_clearing = 1; m_clr_cnt = 0; m_losses = 0;
            m_wren = 0; m_wren_k = 0; m_waddr = 0; m_wdata = 0;
        end else if (m_clearing) begin
            m_wren = 1; m_wren_k = 1;
            m_waddr = 8'(m_clr_cnt); m_wdata = 0;
            m_clr_cnt++;
            if (m_clr_cnt == DEPTH) begin
                m_clearing = 0; m_clr_cnt = 0;
            end
        end else if (clear_req) begin
            m_clearing = 1; m_clr_cnt = 0; m_losses = 0;
            m_wren = 0; m_wren_k = 0;
        end else begin
            ahs = a_valid && rdy[1];
            bhs = b_valid && rdy[0];
            if (bhs) begin
                m_waddr = b_waddr; m_wdata = b_wdata;
            end else if (ahs) begin
                m_waddr = a_waddr; m_wdata = a_wdata;
            end
            m_wren_k = ahs || bhs;
            m_wren   = m_wren_k && ((m_waddr % 32) != 0);
            if (bhs || !b_valid) m_losses = 0;
            else if (ahs)        m_losses = (m_losses < STARVE) ? m_losses + 1 : STARVE;
        end
    end

    always @(negedge clock) begin
        logic [1:0] rdy;
        if (m_valid) begin
            rdy = model_ready();
            check("model a_ready", a_ready, rdy[1]);
            check("model b_ready", b_ready, rdy[0]);
            check("model busy", busy, m_clearing);
            check("model rf_wren", rf_wren, m_wren);
            check("model rf_waddr", rf_waddr, m_waddr);
            check("model rf_wdata", rf_wdata, m_wdata);
            check("model keep a_ready", a_ready_k, rdy[1]);
            check("model keep b_ready", b_ready_k, rdy[0]);
            check("model keep busy", busy_k, m_clearing);
            check("model keep rf_wren", rf_wren_k, m_wren_k);
            check("model keep rf_waddr", rf_waddr_k, m_waddr);
            check("model keep rf_wdata", rf_wdata_k, m_wdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic watch_clear(input int budget, input bit stop_on_a,
                               output int n_writes, output bit accepted);
        n_writes = 0;
        accepted = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (busy) check("no ready while clearing", {a_ready, b_ready}, 2'b00);
            if (rf_wren) begin
                check("clear addr order", rf_waddr, n_writes[7:0]);
                check("clear data zero", rf_wdata, 32'h0);
                if (n_writes == 0)   check("busy at first clear write", busy, 1'b1);
                if (n_writes == 255) check("busy at last clear write", busy, 1'b0);
                n_writes++;
            end
            if (stop_on_a && a_valid && a_ready) begin
                accepted = 1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  acc;
        bit  found;
        logic [7:0] pattern;

        // Reset, then idle through the whole power-on clear.
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("reset busy", busy, 1'b1);
        check("reset rf_wren", rf_wren, 1'b0);
        check("reset rf_waddr", rf_waddr, 8'h00);
        check("reset readies", {a_ready, b_ready}, 2'b00);
        watch_clear(300, 0, n, acc);
        check("power-on clear write count", n, 256);
        check("busy after clear", busy, 1'b0);

        // A alone.
        tick(); a_valid = 1; a_waddr = 8'h21; a_wdata = 32'hDEADBEEF;
        @(negedge clock);
        check("A only a_ready", a_ready, 1'b1);
        tick(); a_valid = 0;
        @(negedge clock);
        check("A only rf_wren", rf_wren, 1'b1);
        check("A only rf_waddr", rf_waddr, 8'h21);
        check("A only rf_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        @(negedge clock);
        check("A only wren drops", rf_wren, 1'b0);

        // B to hart 2 x0: accepted, written only when ZERO_DROP=0.
        tick(); b_valid = 1; b_waddr = 8'h40; b_wdata = 32'hCAFEF00D;
        @(negedge clock);
        check("x0 b_ready", b_ready, 1'b1);
        tick(); b_valid = 0;
        @(negedge clock);
        check("x0 dropped rf_wren", rf_wren, 1'b0);
        check("x0 kept rf_wren", rf_wren_k, 1'b1);
        check("x0 kept rf_waddr", rf_waddr_k, 8'h40);
        check("x0 kept rf_wdata", rf_wdata_k, 32'hCAFEF00D);

        // Sustained contention: A,A,A,B repeating.
        tick();
        a_valid = 1; a_waddr = 8'h05; a_wdata = 32'hAAAA0005;
        b_valid = 1; b_waddr = 8'h06; b_wdata = 32'hBBBB0006;
        pattern = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            pattern[i] = b_valid && b_ready;
        end
        check("contention grant pattern", pattern, 8'h88);
        tick(); a_valid = 0; b_valid = 0;
        @(negedge clock);
        check("contention last write is B", rf_waddr, 8'h06);

        // clear_req while A waits.
        tick(); a_valid = 1; a_waddr = 8'h22; a_wdata = 32'h12345678; clear_req = 1;
        @(negedge clock);
        check("clear_req blocks a_ready", a_ready, 1'b0);
        tick(); clear_req = 0;
        @(negedge clock);
        check("clear_req gap rf_wren", rf_wren, 1'b0);
        check("clear_req gap busy", busy, 1'b1);
        watch_clear(300, 1, n, acc);
        check("re-clear write count", n, 256);
        check("A accepted after re-clear", acc, 1'b1);
        tick(); a_valid = 0;
        @(negedge clock);
        check("post-clear A rf_wren", rf_wren, 1'b1);
        check("post-clear A rf_waddr", rf_waddr, 8'h22);
        check("post-clear A rf_wdata", rf_wdata, 32'h12345678);

        // Reset in the middle of a clear.
        tick(); clear_req = 1;
        tick(); clear_req = 0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (rf_wren && rf_waddr == 8'd99) begin
                found = 1;
                break;
            end
        end
        check("reached clear index 100", found, 1'b1);
        reset = 1;
        @(posedge clock);
        #1 reset = 0; a_valid = 1; a_waddr = 8'h23; a_wdata = 32'h0BADF00D;
        @(negedge clock);
        check("mid-clear reset rf_wren", rf_wren, 1'b0);
        check("mid-clear reset busy", busy, 1'b1);
        watch_clear(300, 1, n, acc);
        check("restarted clear write count", n, 256);
        check("A accepted after restart", acc, 1'b1);
        tick(); a_valid = 0;
        @(negedge clock);
        check("post-restart A rf_waddr", rf_waddr, 8'h23);
        check("post-restart A rf_wdata", rf_wdata, 32'h0BADF00D);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port controller for the 256-entry, 1-write/2-read register file (8 harts x 32 regs).
- Shares the single write port between two writeback requesters: A (execute, priority) and B (load/memory response), with a starvation guard for B.
- Sequences a hardware clear of all entries after reset or on request.
- Drops writes to each hart's x0.
- Sits between the writeback stages and the regfile write fields (waddr/wdata/wren).

Parameters:
DEPTH, 256, number of regfile entries to clear
ADDR_W, 8, regfile address width
DATA_W, 32, write data width
REG_BITS, 5, low address bits selecting a register within a hart
STARVE_LIMIT, 3, consecutive cycles B may lose to A before B is forced through (>=1)
ZERO_DROP, 1, when 1, writes with waddr[REG_BITS-1:0]==0 are accepted but not written

Ports:
clock  in  1  global clock
reset  in  1  synchronous, active-high reset
a_valid  in  1  requester A write pending
a_ready  out  1  A accepted this cycle when a_valid&&a_ready
a_waddr  in  ADDR_W  A write address
a_wdata  in  DATA_W  A write data
b_valid  in  1  requester B write pending
b_ready  out  1  B accepted this cycle when b_valid&&b_ready
b_waddr  in  ADDR_W  B write address
b_wdata  in  DATA_W  B write data
clear_req  in  1  one-cycle request to re-clear the whole regfile
rf_waddr  out  ADDR_W  regfile write address (registered)
rf_wdata  out  DATA_W  regfile write data (registered)
rf_wren  out  1  regfile write enable (registered)
busy  out  1  high while clearing

Behaviour:
- Clock is clock; reset is synchronous, active-high, sampled on posedge clock.
- Reset: state=CLEAR, clr_idx=0, starve_cnt=0, rf_wren=0, rf_waddr=0, rf_wdata=0. busy=1 and a_ready=b_ready=0 from the first cycle after reset.
- States: CLEAR, RUN.
- CLEAR
  - Each cycle registers rf_wren=1, rf_waddr=clr_idx, rf_wdata=0, then clr_idx++.
  - After the write of clr_idx==DEPTH-1 is registered: clr_idx returns to 0 and state=RUN.
  - Exactly DEPTH clear writes. busy=1 and both readies=0 throughout. clear_req is ignored.
- RUN (combinational readies, both gated by !clear_req):
  - force_b = b_valid && starve_cnt==STARVE_LIMIT
  - b_ready = !a_valid || force_b
  - a_ready = !force_b
  - a_ready does not depend on a_valid. A must hold its request while not ready.
- starve_cnt
  - Increments (saturating at STARVE_LIMIT) when a_valid && b_valid && A is granted.
  - Clears to 0 on any B handshake, or when b_valid=0.
  - Width is clog2(STARVE_LIMIT+1).
- Output
  - A handshake in cycle N drives rf_* during cycle N+1. The regfile commits at the end of N+1; its forwarding covers same-cycle reads.
  - rf_wren=1 only if the handshake occurred and not (ZERO_DROP && waddr[REG_BITS-1:0]==0).
  - rf_waddr/rf_wdata take the granted requester's values. With no handshake they hold their previous values.
  - At most one handshake per cycle.
- clear_req in RUN: readies forced low that cycle, so no handshake. Next cycle state=CLEAR, clr_idx=0, starve_cnt=0, rf_wren=0 for that cycle. Clear writes start the following cycle.
- Reset mid-CLEAR restarts the clear from index 0. Reset mid-RUN discards any pending grant.
- Address width: DEPTH must equal 2^ADDR_W. clr_idx is ADDR_W+1 bits so the terminal compare is clean.

Decomposition:
- Package regfile_pkg:
  - wb_req struct {waddr[7:0], wdata[31:0]}
  - state enum {CLEAR, RUN}
  - constants RF_DEPTH=256, RF_REG_BITS=5
- One sub-module, regfile_clear_seq: clr_idx counter with start/done and registered zero-write outputs. Arbitration and starve_cnt stay in the top.

Test Plan:
- Reset then idle for 300 cycles -> rf_wren=1 for exactly 256 cycles, addrs 0..255 in order, wdata=0. busy falls after the 256th. a_ready=b_ready=0 during the clear.
- RUN, A only: a_valid, waddr=0x21, wdata=0xDEADBEEF for 1 cycle -> a_ready=1. Next cycle rf_wren=1, rf_waddr=0x21, rf_wdata=0xDEADBEEF; following cycle rf_wren=0.
- Zero drop: B writes waddr=0x40 -> b_ready=1 and the handshake completes, but rf_wren=0 next cycle. With ZERO_DROP=0 the write appears.
- Contention, STARVE_LIMIT=3: a_valid and b_valid held high with distinct data -> grant pattern A,A,A,B repeating. b_ready=1 and a_ready=0 on every 4th cycle. starve_cnt returns to 0 after each B grant.
- clear_req pulse while a_valid=1 in RUN -> a_ready=0 that cycle; next cycle rf_wren=0; then 256 zero writes; then A is accepted and written.
- Assert reset when clr_idx=100 -> the clear restarts at address 0 and completes a full 256 writes; no request is accepted until busy=0.
